// File: rtl/osd_diag_event_packetizer.sv
// Diagnosis event packetizer: buffers {ts, id, payload} records in a FIFO and serialises each as a DII event packet.
// Optional macro OSD_DIAG_OVERFLOW_CNT_EN adds a saturating drop counter reported through overflow packets.
package osd_dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module osd_diag_event_packetizer
    import osd_dii_pkg::*;
#(
    parameter int PAYLOAD_WORDS = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_PKT_LEN   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  id,
    input  logic [15:0]                 event_dest,
    input  logic                        enable,
    input  logic                        event_valid,
    output logic                        event_ready,
    input  logic [31:0]                 event_ts,
    input  logic [15:0]                 event_id,
    input  logic [16*PAYLOAD_WORDS-1:0] event_payload,
    output dii_flit                     debug_out,
    input  logic                        debug_out_ready
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int WW    = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam int REC_W = 48 + 16 * PAYLOAD_WORDS;
    localparam logic [WW-1:0] LAST_WORD = WW'(PAYLOAD_WORDS - 1);

    generate
        if (6 + PAYLOAD_WORDS > MAX_PKT_LEN) begin : g_len_check
            $error("osd_diag_event_packetizer: 6+PAYLOAD_WORDS exceeds MAX_PKT_LEN");
        end
        if (PAYLOAD_WORDS < 1 || PAYLOAD_WORDS > 16) begin : g_words_check
            $error("osd_diag_event_packetizer: PAYLOAD_WORDS must be 1..16");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
            $error("osd_diag_event_packetizer: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_IDLE, S_DEST, S_SRC, S_TYPE, S_TSLO, S_TSHI, S_EVID, S_PAYLOAD
`ifdef OSD_DIAG_OVERFLOW_CNT_EN
        , S_ODEST, S_OSRC, S_OTYPE, S_OCNT
`endif
    } state_t;

    state_t          state_reg;
    logic [WW-1:0]   word_reg;
    logic [WW-1:0]   word_next;
    logic            valid_reg;
    logic            last_reg;
    logic [15:0]     data_reg;

    logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      wr_ptr_next, rd_ptr_next;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             flit_hs;
    logic             have_rec_next;
    logic             start_take;
    state_t           start_state;
    logic             start_valid;
    logic [15:0]      start_data;

    logic [REC_W-1:0] head_rec;
    logic [31:0]      head_ts;
    logic [15:0]      head_id;
    logic [15:0]      head_words [PAYLOAD_WORDS];

    // Full is judged on the pointers before any pop of this cycle.
    assign fifo_full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign event_ready = !fifo_full;
    assign push        = event_valid && enable && !fifo_full;
    assign flit_hs     = valid_reg && debug_out_ready;
    assign pop         = flit_hs && (state_reg == S_PAYLOAD) && (word_reg == LAST_WORD);
    assign wr_ptr_next = wr_ptr_reg + (AW+1)'(push);
    assign rd_ptr_next = rd_ptr_reg + (AW+1)'(pop);
    assign have_rec_next = (wr_ptr_next != rd_ptr_next);
    assign word_next   = word_reg + 1'b1;

    // The head record is read in place; it stays until the last flit is accepted.
    assign head_rec = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign head_ts  = head_rec[31:0];
    assign head_id  = head_rec[47:32];

    genvar gi;
    generate
        for (gi = 0; gi < PAYLOAD_WORDS; gi++) begin : g_head_words
            assign head_words[gi] = head_rec[48 + 16*gi +: 16];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {event_payload, event_id, event_ts};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

`ifdef OSD_DIAG_OVERFLOW_CNT_EN
    logic [15:0] drop_cnt_reg;
    logic [15:0] drop_cnt_next;
    logic [15:0] drop_cnt_base;
    logic [15:0] ovf_cnt_reg;
    logic        drop;

    assign drop = event_valid && enable && fifo_full;

    // Subtract only what was reported so drops arriving meanwhile survive.
    always_comb begin
        drop_cnt_base = drop_cnt_reg;
        if (flit_hs && state_reg == S_OCNT) begin
            drop_cnt_base = drop_cnt_reg - ovf_cnt_reg;
        end
        drop_cnt_next = drop_cnt_base;
        if (drop && drop_cnt_base != 16'hFFFF) begin
            drop_cnt_next = drop_cnt_base + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
            ovf_cnt_reg  <= '0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
            if (start_take && start_state == S_ODEST) begin
                ovf_cnt_reg <= drop_cnt_next;
            end
        end
    end
`endif

    // Points where a new packet may begin: idle, or the final flit of a packet being accepted.
    always_comb begin
        start_take = (state_reg == S_IDLE) || pop;
`ifdef OSD_DIAG_OVERFLOW_CNT_EN
        if (flit_hs && state_reg == S_OCNT) begin
            start_take = 1'b1;
        end
`endif
    end

    always_comb begin
        start_state = S_IDLE;
        start_valid = 1'b0;
        start_data  = 16'h0000;
        if (have_rec_next) begin
            start_state = S_DEST;
            start_valid = 1'b1;
            start_data  = event_dest;
        end
`ifdef OSD_DIAG_OVERFLOW_CNT_EN
        if (drop_cnt_next != 16'h0000) begin
            start_state = S_ODEST;
            start_valid = 1'b1;
            start_data  = event_dest;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            word_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            data_reg  <= 16'h0000;
        end else if (start_take) begin
            state_reg <= start_state;
            word_reg  <= '0;
            valid_reg <= start_valid;
            last_reg  <= 1'b0;
            data_reg  <= start_data;
        end else if (flit_hs) begin
            case (state_reg)
                S_DEST: begin
                    state_reg <= S_SRC;
                    data_reg  <= {6'b0, id};
                end
                S_SRC: begin
                    state_reg <= S_TYPE;
                    data_reg  <= {2'b10, 4'h0, 10'h0};
                end
                S_TYPE: begin
                    state_reg <= S_TSLO;
                    data_reg  <= head_ts[15:0];
                end
                S_TSLO: begin
                    state_reg <= S_TSHI;
                    data_reg  <= head_ts[31:16];
                end
                S_TSHI: begin
                    state_reg <= S_EVID;
                    data_reg  <= head_id;
                end
                S_EVID: begin
                    state_reg <= S_PAYLOAD;
                    word_reg  <= '0;
                    data_reg  <= head_words[0];
                    last_reg  <= (PAYLOAD_WORDS == 1);
                end
                S_PAYLOAD: begin
                    word_reg <= word_next;
                    data_reg <= head_words[word_next];
                    last_reg <= (word_next == LAST_WORD);
                end
`ifdef OSD_DIAG_OVERFLOW_CNT_EN
                S_ODEST: begin
                    state_reg <= S_OSRC;
                    data_reg  <= {6'b0, id};
                end
                S_OSRC: begin
                    state_reg <= S_OTYPE;
                    data_reg  <= {2'b10, 4'h1, 10'h0};
                end
                S_OTYPE: begin
                    state_reg <= S_OCNT;
                    data_reg  <= ovf_cnt_reg;
                    last_reg  <= 1'b1;
                end
`endif
                default: begin
                    state_reg <= S_IDLE;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign debug_out = {valid_reg, last_reg, data_reg};

endmodule

// File: tb/tb_osd_diag_event_packetizer.sv
// Bench for osd_diag_event_packetizer: directed scenarios plus random traffic against a packet-level model.
// Builds with or without OSD_DIAG_OVERFLOW_CNT_EN.
module tb_osd_diag_event_packetizer;
    import osd_dii_pkg::*;

    localparam int PW = 2;
    localparam int FD = 4;
    localparam logic [9:0]  MY_ID = 10'h2A5;
    localparam logic [15:0] DEST  = 16'h1C3E;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id;
    logic [15:0] event_dest;
    logic        enable;
    logic        event_valid;
    logic        event_ready;
    logic [31:0] event_ts;
    logic [15:0] event_id;
    logic [16*PW-1:0] event_payload;
    dii_flit     debug_out;
    logic        debug_out_ready;

    int vectors = 0;
    int miscompares = 0;
    int accepted = 0;
    int popped = 0;
    int model_drops = 0;
    logic [16:0] rx_q[$];
    logic [16:0] exp_q[$];
    int pkt_kind[$];
    int ovf_cnts[$];
    int mon_pos = 0;
    logic [15:0] mon_type = 16'h0;

    osd_diag_event_packetizer #(
        .PAYLOAD_WORDS(PW), .FIFO_DEPTH(FD), .MAX_PKT_LEN(8)
    ) dut (
        .clk(clk), .rst(rst), .id(id), .event_dest(event_dest), .enable(enable),
        .event_valid(event_valid), .event_ready(event_ready), .event_ts(event_ts),
        .event_id(event_id), .event_payload(event_payload), .debug_out(debug_out),
        .debug_out_ready(debug_out_ready)
    );

    always #5 clk = ~clk;

    // Collect accepted flits; a finished record packet means its FIFO slot is gone.
    always @(negedge clk) begin
        if (!rst && debug_out.valid && debug_out_ready) begin
            rx_q.push_back({debug_out.last, debug_out.data});
            if (mon_pos == 2) mon_type = debug_out.data;
            if (debug_out.last) begin
                if (mon_type == 16'h8000) popped++;
                mon_pos = 0;
            end else begin
                mon_pos++;
            end
        end
    end

    task automatic push_expected(input logic [31:0] ts, input logic [15:0] eid, input logic [16*PW-1:0] pl);
        exp_q.push_back({1'b0, DEST});
        exp_q.push_back({1'b0, 6'b0, MY_ID});
        exp_q.push_back({1'b0, 16'h8000});
        exp_q.push_back({1'b0, ts[15:0]});
        exp_q.push_back({1'b0, ts[31:16]});
        exp_q.push_back({1'b0, eid});
        for (int w = 0; w < PW; w++) exp_q.push_back({(w == PW-1), pl[w*16 +: 16]});
    endtask

    // One cycle of producer activity; the model decides accept/drop from occupancy.
    task automatic drive_cycle(input bit v, input logic [31:0] ts, input logic [15:0] eid, input logic [16*PW-1:0] pl);
        event_valid = v;
        event_ts = ts;
        event_id = eid;
        event_payload = pl;
        if (v && enable) begin
            if (accepted - popped < FD) begin
                accepted++;
                push_expected(ts, eid, pl);
            end else begin
                model_drops++;
            end
        end
        @(posedge clk); #1;
        event_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        debug_out_ready = 1'b1;
        while (!(popped == accepted && !debug_out.valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 1000) begin
            miscompares++;
            $display("FAIL %s drain_timeout: popped=%0d required=%0d valid=%0b", tag, popped, accepted, debug_out.valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_stream(input string tag);
        logic [16:0] pkt[$];
        logic [16:0] e;
        int ovf_sum = 0;
        int exp_ovf;
        bit done;
        drain(tag);
        pkt_kind.delete();
        ovf_cnts.delete();
        while (rx_q.size() > 0) begin
            pkt.delete();
            done = 1'b0;
            while (!done && rx_q.size() > 0) begin
                pkt.push_back(rx_q.pop_front());
                done = pkt[pkt.size()-1][16];
            end
            if (pkt.size() >= 3 && pkt[2][15:0] == 16'h8400) begin
                vectors++;
                if (pkt.size() != 4 || pkt[0] !== {1'b0, DEST} || pkt[1] !== {1'b0, 6'b0, MY_ID} || pkt[3][16] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s ovf_pkt_format: len=%0d dest=%h src=%h required len=4 dest=%h src=%h",
                             tag, pkt.size(), pkt[0], pkt[1], DEST, MY_ID);
                end
                pkt_kind.push_back(1);
                if (pkt.size() >= 4) begin
                    ovf_cnts.push_back(int'(pkt[3][15:0]));
                    ovf_sum += int'(pkt[3][15:0]);
                end
            end else begin
                pkt_kind.push_back(0);
                vectors++;
                if (pkt.size() != 6 + PW) begin
                    miscompares++;
                    $display("FAIL %s pkt_len: got=%0d required=%0d", tag, pkt.size(), 6 + PW);
                end
                for (int i = 0; i < 6 + PW; i++) begin
                    e = 17'h1FFFF;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    if (i < pkt.size()) begin
                        vectors++;
                        if (pkt[i] !== e) begin
                            miscompares++;
                            $display("FAIL %s flit%0d: got={last=%0b,%h} required={last=%0b,%h}",
                                     tag, i, pkt[i][16], pkt[i][15:0], e[16], e[15:0]);
                        end
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s missing_flits: got=%0d outstanding required=0", tag, exp_q.size());
            exp_q.delete();
        end
`ifdef OSD_DIAG_OVERFLOW_CNT_EN
        exp_ovf = model_drops;
`else
        exp_ovf = 0;
`endif
        vectors++;
        if (ovf_sum != exp_ovf) begin
            miscompares++;
            $display("FAIL %s ovf_total: got=%0d required=%0d", tag, ovf_sum, exp_ovf);
        end
        model_drops = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors += 4;
        if (debug_out.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got=%b required=0", debug_out.valid); end
        if (debug_out.last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got=%b required=0", debug_out.last); end
        if (debug_out.data !== 16'h0) begin miscompares++; $display("FAIL reset_data: got=%h required=0000", debug_out.data); end
        if (event_ready !== 1'b1) begin miscompares++; $display("FAIL reset_event_ready: got=%b required=1", event_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        debug_out_ready = 1'b1;
        drive_cycle(1'b1, 32'hA5A5_1234, 16'h0007, {16'hBEEF, 16'hCAFE});
        vectors++;
        if (debug_out.valid !== 1'b1 || debug_out.data !== DEST) begin
            miscompares++;
            $display("FAIL single_latency: valid=%b data=%h required valid=1 data=%h", debug_out.valid, debug_out.data, DEST);
        end
        check_stream("single");
    endtask

    task automatic test_stall_toggle();
        int start;
        int cyc = 0;
        logic [15:0] held_data;
        logic held_last;
        bit stalled;
        debug_out_ready = 1'b1;
        start = popped;
        drive_cycle(1'b1, 32'hA5A5_1234, 16'h0007, {16'hBEEF, 16'hCAFE});
        while (popped == start && cyc < 100) begin
            debug_out_ready = (cyc % 2 == 0) ? 1'b0 : 1'b1;
            stalled = debug_out.valid && !debug_out_ready;
            held_data = debug_out.data;
            held_last = debug_out.last;
            @(posedge clk); #1;
            if (stalled) begin
                vectors++;
                if (debug_out.valid !== 1'b1 || debug_out.data !== held_data || debug_out.last !== held_last) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                             debug_out.valid, debug_out.data, debug_out.last, held_data, held_last);
                end
            end
            cyc++;
        end
        check_stream("stall_toggle");
    endtask

    task automatic test_burst_drop();
        debug_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, $urandom, 16'h0100 + 16'(i), {16'($urandom), 16'($urandom)});
            if (i == 2 || i == 3) begin
                vectors++;
                if (event_ready !== (i == 2)) begin
                    miscompares++;
                    $display("FAIL burst_event_ready_%0d: got=%b required=%b", i + 1, event_ready, (i == 2));
                end
            end
        end
        check_stream("burst_drop");
        vectors++;
`ifdef OSD_DIAG_OVERFLOW_CNT_EN
        if (pkt_kind.size() != 5 || pkt_kind[1] != 1 || ovf_cnts.size() != 1 || ovf_cnts[0] != 2) begin
            miscompares++;
            $display("FAIL burst_ovf_order: packets=%0d second_kind=%0d ovf_pkts=%0d required packets=5 second=overflow count=2",
                     pkt_kind.size(), (pkt_kind.size() > 1) ? pkt_kind[1] : -1, ovf_cnts.size());
        end
`else
        if (pkt_kind.size() != 4) begin
            miscompares++;
            $display("FAIL burst_pkt_count: got=%0d required=4", pkt_kind.size());
        end
`endif
    endtask

`ifdef OSD_DIAG_OVERFLOW_CNT_EN
    task automatic test_ocnt_drop();
        debug_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, $urandom, 16'h0200 + 16'(i), {16'($urandom), 16'($urandom)});
        debug_out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        debug_out_ready = 1'b0;
        drive_cycle(1'b1, $urandom, 16'h0205, {16'($urandom), 16'($urandom)});
        debug_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (debug_out.valid !== 1'b1 || debug_out.last !== 1'b1 || debug_out.data !== 16'h0001) begin
            miscompares++;
            $display("FAIL ocnt_flit: got valid=%b last=%b data=%h required 1 1 0001", debug_out.valid, debug_out.last, debug_out.data);
        end
        drive_cycle(1'b1, $urandom, 16'h0206, {16'($urandom), 16'($urandom)});
        check_stream("ocnt_drop");
        vectors++;
        if (pkt_kind.size() != 7 || ovf_cnts.size() != 2 || ovf_cnts[1] != 1 || pkt_kind[2] != 1) begin
            miscompares++;
            $display("FAIL ocnt_follow_ovf: packets=%0d ovf_pkts=%0d required packets=7 ovf_pkts=2 second count=1",
                     pkt_kind.size(), ovf_cnts.size());
        end
    endtask
`endif

    task automatic test_enable_off();
        debug_out_ready = 1'b0;
        drive_cycle(1'b1, 32'h1111_0001, 16'h0301, {16'h00A1, 16'h00B1});
        drive_cycle(1'b1, 32'h1111_0002, 16'h0302, {16'h00A2, 16'h00B2});
        enable = 1'b0;
        drive_cycle(1'b1, 32'h1111_0003, 16'h0303, {16'h00A3, 16'h00B3});
        check_stream("enable_off");
        vectors++;
        if (pkt_kind.size() != 2) begin
            miscompares++;
            $display("FAIL enable_off_pkts: got=%0d required=2", pkt_kind.size());
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            debug_out_ready = ($urandom_range(9) < 7);
            drive_cycle(($urandom_range(9) < 4), $urandom, 16'($urandom), {16'($urandom), 16'($urandom)});
        end
        check_stream("random");
    endtask

    task automatic test_reset_mid();
        debug_out_ready = 1'b1;
        drive_cycle(1'b1, 32'h7777_8888, 16'h0401, {16'h9999, 16'hAAAA});
        drive_cycle(1'b1, 32'h7777_8889, 16'h0402, {16'h9998, 16'hAAAB});
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (debug_out.data !== 16'hAAAA) begin
            miscompares++;
            $display("FAIL midpkt_payload: got=%h required=AAAA", debug_out.data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (debug_out.valid !== 1'b0 || debug_out.last !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_valid: got valid=%b last=%b required 0 0", debug_out.valid, debug_out.last);
        end
        rx_q.delete();
        exp_q.delete();
        accepted = 0;
        popped = 0;
        mon_pos = 0;
        model_drops = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (debug_out.valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_fifo_empty: got valid=%b required 0 (cycle %0d)", debug_out.valid, i);
            end
        end
        drive_cycle(1'b1, 32'h0BAD_F00D, 16'h0403, {16'h1357, 16'h2468});
        vectors++;
        if (debug_out.valid !== 1'b1 || debug_out.data !== DEST) begin
            miscompares++;
            $display("FAIL midrst_restart: valid=%b data=%h required valid=1 data=%h", debug_out.valid, debug_out.data, DEST);
        end
        check_stream("after_reset");
    endtask

    initial begin
        rst = 1'b1;
        id = MY_ID;
        event_dest = DEST;
        enable = 1'b1;
        event_valid = 1'b0;
        event_ts = '0;
        event_id = '0;
        event_payload = '0;
        debug_out_ready = 1'b0;
        test_reset();
        test_single();
        test_stall_toggle();
        test_burst_drop();
`ifdef OSD_DIAG_OVERFLOW_CNT_EN
        test_ocnt_drop();
`endif
        test_enable_off();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
